// File: rtl/pc_upstream_arbiter.sv
// Round-robin, message-granular arbiter sharing the 32-bit PC upstream channel among NIN sources.
// Optional per-source word counters are built when PC_UPSTREAM_ARB_STATS_EN is defined.

`ifdef PC_UPSTREAM_ARB_STATS_EN
module pc_upstream_arbiter_cnt #(
    parameter int NCNT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clr,
    input  logic            inc,
    output logic [NCNT-1:0] cnt
);
    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               cnt <= '0;
        else if (clr)             cnt <= '0;
        else if (inc && ~&cnt)    cnt <= cnt + 1'b1;
    end
endmodule
`endif

module pc_upstream_arbiter #(
    parameter  int NIN     = 4,
    parameter  int NPCcode = 8,
    parameter  int NPCdata = 24,
    parameter  int NCNT    = 16,
    localparam int NW      = NPCcode + NPCdata,
    localparam int IW      = $clog2(NIN)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NIN-1:0]    in_v,
    input  logic [NIN*NW-1:0] in_d,
    input  logic [NIN-1:0]    in_last,
    output logic [NIN-1:0]    in_a,
    output logic              out_v,
    output logic [NW-1:0]     out_d,
    input  logic              out_a,
    output logic [IW-1:0]     grant_id,
    output logic              locked,
    input  logic [IW-1:0]     stat_sel,
    input  logic              stat_clr,
    output logic [NCNT-1:0]   stat_cnt
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [IW-1:0] ptr, owner, sel;
    logic [IW:0]   cand;
    logic          found, free, xfer;

    // Search ptr+1, ptr+2, ... with wrap; iterating downward lets the nearest hit win.
    always_comb begin
        sel   = owner;
        found = 1'b0;
        cand  = '0;
        if (state == LOCKED) begin
            found = in_v[owner];
        end else begin
            for (int k = NIN; k >= 1; k--) begin
                cand = {1'b0, ptr} + (IW+1)'(k);
                if (cand >= (IW+1)'(NIN)) cand = cand - (IW+1)'(NIN);
                if (in_v[cand[IW-1:0]]) begin
                    sel   = cand[IW-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign free = ~out_v | out_a;
    assign xfer = found & free;

    always_comb begin
        in_a      = '0;
        in_a[sel] = xfer;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_v    <= 1'b0;
            out_d    <= '0;
            state    <= IDLE;
            ptr      <= IW'(NIN-1);
            owner    <= '0;
            grant_id <= '0;
            locked   <= 1'b0;
        end else if (xfer) begin
            out_v    <= 1'b1;
            out_d    <= in_d[sel*NW +: NW];
            grant_id <= sel;
            if (in_last[sel]) begin
                state  <= IDLE;
                locked <= 1'b0;
                ptr    <= sel;
            end else begin
                state  <= LOCKED;
                locked <= 1'b1;
                owner  <= sel;
            end
        end else if (out_a) begin
            out_v <= 1'b0;
        end
    end

`ifdef PC_UPSTREAM_ARB_STATS_EN
    logic [NIN-1:0][NCNT-1:0] cnt;

    for (genvar i = 0; i < NIN; i++) begin : g_cnt
        pc_upstream_arbiter_cnt #(.NCNT(NCNT)) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (stat_clr),
            .inc   (in_a[i]),
            .cnt   (cnt[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     stat_cnt <= '0;
        else if (int'(stat_sel) < NIN)  stat_cnt <= cnt[stat_sel];
        else                            stat_cnt <= '0;
    end
`else
    // Ports kept for a uniform interface; the value is always zero.
    assign stat_cnt = {NCNT{1'b0}} & {NCNT{^{stat_sel, stat_clr}}};
`endif

endmodule
